// File: rtl/ula_arbitro_if.sv
// ula_arbitro_if: request/response bus between the execution-unit requesters
// and the shared-ALU arbiter.
//   req_valid/req_ready : per-requester handshake (bit i = requester i)
//   req_a/req_b         : 32-bit operands, slice [32i+31:32i]
//   req_f               : 2-bit ALU op, slice [2i+1:2i] (00 add, 01 sub, 10 and, 11 or)
//   rsp_valid/rsp_ready : response handshake
//   rsp_id              : requester index of the response
//   rsp_resultado       : ALU result
//   rsp_flags           : {Negativo, Zero, Carry, Overflow}
// master = requester/consumer side, slave = arbiter side.
interface ula_arbitro_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ*2-1:0]  req_f;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_resultado;
    logic [3:0]            rsp_flags;

    modport master (
        output req_valid, req_a, req_b, req_f, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_resultado, rsp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, req_f, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_resultado, rsp_flags
    );
endinterface

// File: rtl/ula_arbitro.sv
// ula_arbitro: round-robin arbiter sharing one 32-bit ALU (add/sub/and/or with
// Negativo/Zero/Carry/Overflow flags) among NUM_REQ requesters, 2-stage pipeline.
//   clk  : clock, all state on rising edge
//   rst  : synchronous reset, active-high
//   bus  : ula_arbitro_if.slave (request handshakes, tagged response bus)
//   busy : any pipeline stage holds a valid op
// S1 registers {a, b, f, id}; the ALU works combinationally from S1.
// S2 registers {resultado, flags, id} and drives the response bus.
module ula_arbitro #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic         clk,
    input  logic         rst,
    ula_arbitro_if.slave bus,
    output logic         busy
);

    logic [ID_W-1:0]    ptr;
    logic               s1_valid;
    logic [31:0]        s1_a;
    logic [31:0]        s1_b;
    logic [1:0]         s1_f;
    logic [ID_W-1:0]    s1_id;
    logic               s2_valid;
    logic [31:0]        s2_res;
    logic [3:0]         s2_flags;
    logic [ID_W-1:0]    s2_id;

    logic               s2_adv;
    logic               s1_adv;
    logic               accept;
    logic               xfer;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    idx;
    logic               found;

    logic [31:0]        a_arr [NUM_REQ];
    logic [31:0]        b_arr [NUM_REQ];
    logic [1:0]         f_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = bus.req_a[32*g +: 32];
        assign b_arr[g] = bus.req_b[32*g +: 32];
        assign f_arr[g] = bus.req_f[2*g +: 2];
    end

    assign s2_adv = !s2_valid || bus.rsp_ready;
    assign s1_adv = s1_valid && s2_adv;
    assign accept = !s1_valid || s1_adv;

    // First valid requester starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        idx    = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                gnt_id      = idx;
            end
        end
    end

    // No grant is offered while reset is held, so no requester believes an
    // op was taken that the reset is about to discard.
    assign bus.req_ready = (accept && !rst) ? grant : '0;
    assign xfer          = accept && found && !rst;

    // ALU on S1 contents
    logic [31:0] b_eff;
    logic [32:0] sum33;
    logic [31:0] alu_res;
    logic        alu_c;
    logic        alu_v;

    always_comb begin
        b_eff   = s1_f[0] ? ~s1_b : s1_b;
        sum33   = {1'b0, s1_a} + {1'b0, b_eff} + {32'b0, s1_f[0]};
        alu_res = sum33[31:0];
        case (s1_f)
            2'b10:   alu_res = s1_a & s1_b;
            2'b11:   alu_res = s1_a | s1_b;
            default: alu_res = sum33[31:0];
        endcase
        alu_c = !s1_f[1] && sum33[32];
        alu_v = !s1_f[1] && !(s1_a[31] ^ s1_b[31] ^ s1_f[0]) && (s1_a[31] ^ sum33[31]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_f     <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_flags <= '0;
            s2_id    <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_res   <= alu_res;
                    s2_flags <= {alu_res[31], (alu_res == 32'd0), alu_c, alu_v};
                    s2_id    <= s1_id;
                end
            end
            if (accept) begin
                s1_valid <= found;
                if (found) begin
                    s1_a  <= a_arr[gnt_id];
                    s1_b  <= b_arr[gnt_id];
                    s1_f  <= f_arr[gnt_id];
                    s1_id <= gnt_id;
                end
            end
            if (xfer) begin
                ptr <= (32'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
            end
        end
    end

    assign bus.rsp_valid     = s2_valid;
    assign bus.rsp_id        = s2_id;
    assign bus.rsp_resultado = s2_res;
    assign bus.rsp_flags     = s2_flags;
    assign busy              = s1_valid || s2_valid;

endmodule

// File: tb/tb_ula_arbitro.sv
module tb_ula_arbitro;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   checks   = 0;
    int   failures = 0;

    ula_arbitro_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    ula_arbitro #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
        bus.req_f[i*2 +: 2]   = f;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd0 || bus.rsp_resultado !== 32'd0 || bus.rsp_flags !== 4'd0) begin
            failures++; $display("FAIL reset_rsp_data got id=%0d res=%h fl=%b exp 0/0/0", bus.rsp_id, bus.rsp_resultado, bus.rsp_flags); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        bus.req_valid = '0;
        rst = 1'b0;
    endtask

    // One isolated op: accepted at the next edge, response visible after two edges.
    task automatic test_single(input int id, input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                               input logic [31:0] exp_res, input logic [3:0] exp_fl);
        logic [3:0] exp_rdy;
        exp_rdy = 4'b0001 << id;
        @(negedge clk);
        set_op(id, a, b, f);
        bus.req_valid = exp_rdy;
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== exp_rdy) begin failures++; $display("FAIL single%0d_ready got=%b exp=%b", id, bus.req_ready, exp_rdy); end
        @(negedge clk);
        bus.req_valid = '0;
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL single%0d_early_valid got=%b exp=0", id, bus.rsp_valid); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== ID_W'(id)) begin
            failures++; $display("FAIL single%0d_rsp got valid=%b id=%0d exp valid=1 id=%0d", id, bus.rsp_valid, bus.rsp_id, id); end
        checks++; if (bus.rsp_resultado !== exp_res || bus.rsp_flags !== exp_fl) begin
            failures++; $display("FAIL single%0d_data got res=%h fl=%b exp res=%h fl=%b", id, bus.rsp_resultado, bus.rsp_flags, exp_res, exp_fl); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_res [4];
        logic [3:0]  exp_rdy;
        int          n_rsp;
        exp_res[0] = 32'h100; exp_res[1] = 32'h201; exp_res[2] = 32'h302; exp_res[3] = 32'h403;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'h100 * (i + 1), i, 2'b00);
        n_rsp = 0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k >= 2 && k < 10) begin
                checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== ID_W'((k - 2) % 4) ||
                              bus.rsp_resultado !== exp_res[(k - 2) % 4]) begin
                    failures++; $display("FAIL rr_rsp%0d got valid=%b id=%0d res=%h exp valid=1 id=%0d res=%h",
                                         k, bus.rsp_valid, bus.rsp_id, bus.rsp_resultado, (k - 2) % 4, exp_res[(k - 2) % 4]);
                end
                if (bus.rsp_valid === 1'b1) n_rsp++;
            end
            bus.req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            exp_rdy = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
            checks++; if (bus.req_ready !== exp_rdy) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", k, bus.req_ready, exp_rdy); end
        end
        checks++; if (bus.rsp_valid !== 1'b0 || n_rsp != 8) begin
            failures++; $display("FAIL rr_count got valid=%b n=%0d exp valid=0 n=8", bus.rsp_valid, n_rsp); end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.rsp_ready = 1'b0;
        set_op(0, 32'd10, 32'd1, 2'b00);
        set_op(1, 32'd20, 32'd2, 2'b01);
        bus.req_valid = 4'b0011;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL bp_ready0 got=%b exp=0001", bus.req_ready); end
        @(negedge clk);
        // req0 taken; it now presents a fresh op
        set_op(0, 32'd7, 32'd7, 2'b01);
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL bp_ready1 got=%b exp=0010", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.req_ready !== 4'b0000 || busy !== 1'b1) begin
                failures++; $display("FAIL bp_stall%0d got ready=%b busy=%b exp ready=0000 busy=1", k, bus.req_ready, busy); end
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_resultado !== 32'd11 || bus.rsp_flags !== 4'b0000) begin
                failures++; $display("FAIL bp_hold%0d got valid=%b id=%0d res=%h fl=%b exp 1/0/0000000b/0000",
                                     k, bus.rsp_valid, bus.rsp_id, bus.rsp_resultado, bus.rsp_flags); end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL bp_nobubble got=%b exp=0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_resultado !== 32'd18 || bus.rsp_flags !== 4'b0010) begin
            failures++; $display("FAIL bp_rsp1 got valid=%b id=%0d res=%h fl=%b exp 1/1/00000012/0010",
                                 bus.rsp_valid, bus.rsp_id, bus.rsp_resultado, bus.rsp_flags); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_resultado !== 32'd0 || bus.rsp_flags !== 4'b0110) begin
            failures++; $display("FAIL bp_rsp2 got valid=%b id=%0d res=%h fl=%b exp 1/0/00000000/0110",
                                 bus.rsp_valid, bus.rsp_id, bus.rsp_resultado, bus.rsp_flags); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL bp_drain got valid=%b busy=%b exp 0/0", bus.rsp_valid, busy); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        bus.rsp_ready = 1'b0;
        set_op(1, 32'd1, 32'd1, 2'b00);
        set_op(2, 32'd2, 32'd2, 2'b00);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        // two ops in flight, pointer at 3
        bus.req_valid = '0;
        checks++; if (busy !== 1'b1 || bus.rsp_valid !== 1'b1) begin
            failures++; $display("FAIL midop_inflight got busy=%b valid=%b exp 1/1", busy, bus.rsp_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL midop_flush got valid=%b busy=%b exp 0/0", bus.rsp_valid, busy); end
        bus.req_valid = 4'b1111;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL midop_ptr got=%b exp=0001", bus.req_ready); end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL midop_ghost%0d got valid=%b exp=0", k, bus.rsp_valid); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_f = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_single(0, 32'd5,        32'd3,        2'b01, 32'h0000_0002, 4'b0010);
        test_single(1, 32'h7FFFFFFF, 32'd1,        2'b00, 32'h8000_0000, 4'b1001);
        test_single(2, 32'h12345678, 32'h12345678, 2'b01, 32'h0000_0000, 4'b0110);
        test_single(3, 32'hF0F0F0F0, 32'h0FF00FF0, 2'b10, 32'h00F0_00F0, 4'b0000);
        test_single(3, 32'hF0F0F0F0, 32'h0FF00FF0, 2'b11, 32'hFFF0_FFF0, 4'b1000);
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
